// File: rtl/cache_ctrl_pipe_if.sv
// Bundle of CPU request/response, cache array and RAM handshake signals for cache_ctrl_pipe.
// master = controller side, slave = CPU/array/RAM side.
interface cache_ctrl_pipe_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  // req: accepted on a rising edge where req_valid & req_ready; rsp_valid is a one-cycle pulse, no backpressure.
  // ram: ram_req held until ram_ack (completes that cycle) or until the controller times out and drops it.
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic              req_ind;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] cache_addr;
  logic [1:0]        cache_op;
  logic              cache_wsel;
  logic [DATA_W-1:0] cache_wdata;
  logic              cache_hit;
  logic              cache_clean;
  logic [DATA_W-1:0] cache_rdata;
  logic              ram_req;
  logic              ram_we;
  logic              ram_ack;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    input  req_valid, req_op, req_ind, req_addr, req_wdata,
    input  cache_hit, cache_clean, cache_rdata, ram_ack, ram_rdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
    output cache_addr, cache_op, cache_wsel, cache_wdata, ram_req, ram_we
  );

  modport slave (
    output req_valid, req_op, req_ind, req_addr, req_wdata,
    output cache_hit, cache_clean, cache_rdata, ram_ack, ram_rdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
    input  cache_addr, cache_op, cache_wsel, cache_wdata, ram_req, ram_we
  );
endinterface

// File: rtl/cache_ctrl_pipe.sv
// Direct-mapped write-back cache controller with RAM timeout and one level of indirection.
// Optional hit/miss statistics counters when CACHE_STATS_EN is defined.
module cache_ctrl_pipe #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
`ifdef CACHE_STATS_EN
  parameter int STAT_W      = 16,
`endif
  parameter int RAM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  cache_ctrl_pipe_if.master  bus,
`ifdef CACHE_STATS_EN
  output logic [STAT_W-1:0]  hit_cnt,
  output logic [STAT_W-1:0]  miss_cnt,
`endif
  output logic [3:0]         dbg_state
);
  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_LOOKUP, S_CHECK, S_EVICT, S_FILL, S_REFILL, S_IND_PTR, S_CWRITE, S_DONE
  } state_e;

  localparam logic [1:0] OP_CLEAR = 2'b00, OP_RSVD = 2'b01, OP_READ = 2'b10;
  localparam logic [1:0] C_CLEAR = 2'b00, C_LOOKUP = 2'b01, C_HOLD = 2'b10, C_WRITE = 2'b11;
  localparam int TW = $clog2(RAM_TIMEOUT + 2);
  localparam logic [TW-1:0] TMO_LAST = TW'((RAM_TIMEOUT > 0) ? RAM_TIMEOUT - 1 : 0);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        op_q, op_d;
  logic              ind_q, ind_d;
  logic              err_q, err_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              read_like;
  logic              tmo_expired;

  // A pending pointer fetch behaves like a read: misses must bring the line in.
  assign read_like   = (op_q == OP_READ) || ind_q;
  assign tmo_expired = (RAM_TIMEOUT != 0) && (tmo_q == TMO_LAST);
  assign dbg_state   = state_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    ind_d   = ind_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    bus.req_ready   = 1'b0;
    bus.rsp_valid   = 1'b0;
    bus.rsp_err     = 1'b0;
    bus.rsp_rdata   = '0;
    bus.cache_addr  = addr_q;
    bus.cache_op    = C_HOLD;
    bus.cache_wsel  = 1'b0;
    bus.cache_wdata = wdata_q;
    bus.ram_req     = 1'b0;
    bus.ram_we      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        bus.req_ready   = 1'b1;
        bus.cache_addr  = '0;
        bus.cache_wdata = '0;
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          op_d    = bus.req_op;
          ind_d   = bus.req_ind;
          err_d   = 1'b0;
          if (bus.req_op == OP_CLEAR)     state_d = S_CLEAR;
          else if (bus.req_op == OP_RSVD) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
          else                            state_d = S_LOOKUP;
        end
      end
      S_CLEAR: begin
        bus.cache_op  = C_CLEAR;
        bus.rsp_valid = 1'b1;
        state_d       = S_IDLE;
      end
      S_LOOKUP: begin
        bus.cache_op = C_LOOKUP;
        state_d      = S_CHECK;
      end
      S_CHECK: begin
        if (bus.cache_hit) begin
          if (ind_q)                 state_d = S_IND_PTR;
          else if (op_q == OP_READ)  state_d = S_DONE;
          else                       state_d = S_CWRITE;
        end else if (!bus.cache_clean) begin
          state_d = S_EVICT;
          tmo_d   = '0;
        end else if (read_like) begin
          state_d = S_FILL;
          tmo_d   = '0;
        end else begin
          state_d = S_CWRITE;
        end
      end
      S_EVICT: begin
        bus.ram_req = 1'b1;
        bus.ram_we  = 1'b1;
        if (bus.ram_ack) begin
          if (read_like) begin
            state_d = S_FILL;
            tmo_d   = '0;
          end else begin
            state_d = S_CWRITE;
          end
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_FILL: begin
        bus.ram_req = 1'b1;
        if (bus.ram_ack) begin
          state_d = S_REFILL;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_REFILL: begin
        bus.cache_op   = C_WRITE;
        bus.cache_wsel = 1'b1;
        state_d        = S_CHECK;
      end
      S_IND_PTR: begin
        addr_d  = bus.cache_rdata[ADDR_W-1:0];
        ind_d   = 1'b0;
        state_d = S_LOOKUP;
      end
      S_CWRITE: begin
        bus.cache_op = C_WRITE;
        state_d      = S_DONE;
      end
      S_DONE: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = err_q;
        bus.rsp_rdata = bus.cache_rdata;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= '0;
      ind_q   <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      ind_q   <= ind_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

`ifdef CACHE_STATS_EN
  logic [STAT_W-1:0] hit_q, hit_d, miss_q, miss_d;
  logic              refill_q, refill_d;

  // The CHECK right after REFILL always hits and is not a new access, so it is skipped.
  always_comb begin
    hit_d    = hit_q;
    miss_d   = miss_q;
    refill_d = (state_q == S_REFILL);
    if (state_q == S_CLEAR) begin
      hit_d  = '0;
      miss_d = '0;
    end else if (state_q == S_CHECK && !refill_q) begin
      if (bus.cache_hit) begin
        if (hit_q != '1) hit_d = hit_q + STAT_W'(1);
      end else begin
        if (miss_q != '1) miss_d = miss_q + STAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_q    <= '0;
      miss_q   <= '0;
      refill_q <= 1'b0;
    end else begin
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      refill_q <= refill_d;
    end
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
`endif
endmodule

// File: tb/tb_cache_ctrl_pipe.sv
// Bench for cache_ctrl_pipe: external cache array and RAM models plus a transaction-level cache reference.
// Directed scenarios first, then randomized requests; CACHE_STATS_EN also checks the counters.
module tb_cache_ctrl_pipe;
  localparam int DW  = 8;
  localparam int AW  = 8;
  localparam int TMO = 4;
  localparam int NEVER = 99;

  logic clk = 1'b0;
  logic rst_n;
  logic env_init;
  logic [3:0] dbg_state;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  cache_ctrl_pipe_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  cache_ctrl_pipe #(.DATA_W(DW), .ADDR_W(AW), .RAM_TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
`ifdef CACHE_STATS_EN
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt),
`endif
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- external cache array (16 lines, index = addr[3:0]) ----------------
  logic [DW-1:0] arr_data[16];
  logic [3:0]    arr_tag[16];
  logic          arr_v[16];
  logic          arr_d[16];
  logic [3:0]    a_idx;

  assign a_idx           = bus.cache_addr[3:0];
  assign bus.cache_hit   = arr_v[a_idx] && (arr_tag[a_idx] == bus.cache_addr[7:4]);
  assign bus.cache_clean = !arr_d[a_idx];
  assign bus.cache_rdata = arr_data[a_idx];

  always @(posedge clk) begin
    if (env_init) begin
      for (int i = 0; i < 16; i++) begin
        arr_v[i] <= 1'b0; arr_d[i] <= 1'b0; arr_tag[i] <= '0; arr_data[i] <= '0;
      end
    end else if (bus.cache_op == 2'b11) begin
      arr_data[a_idx] <= bus.cache_wsel ? bus.ram_rdata : bus.cache_wdata;
      arr_tag[a_idx]  <= bus.cache_addr[7:4];
      arr_v[a_idx]    <= 1'b1;
      arr_d[a_idx]    <= !bus.cache_wsel;
    end else if (bus.cache_op == 2'b00) begin
      for (int i = 0; i < 16; i++) begin
        arr_v[i] <= 1'b0; arr_d[i] <= 1'b0;
      end
    end
  end

  // ---------------- RAM responder ----------------
  logic [DW-1:0] ram_phys[256];
  int            dly_q[$];
  logic          we_q[$];

  initial begin
    int  d, cnt;
    bit  busy;
    busy = 1'b0; d = 0; cnt = 0;
    bus.ram_ack   = 1'b0;
    bus.ram_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.ram_ack) begin
        bus.ram_ack = 1'b0;
        busy = 1'b0;
      end else if (busy && !bus.ram_req) begin
        busy = 1'b0;
      end
      if (!busy && bus.ram_req === 1'b1) begin
        busy = 1'b1;
        cnt  = 0;
        check_eq("ram_xfer_expected", 32'(dly_q.size() > 0), 1);
        d = (dly_q.size() > 0) ? dly_q.pop_front() : NEVER;
        if (we_q.size() > 0) check_eq("ram_we", bus.ram_we, we_q.pop_front());
      end
      if (busy) begin
        if (cnt == d) begin
          bus.ram_ack = 1'b1;
          if (bus.ram_we) ram_phys[{arr_tag[a_idx], a_idx}] = arr_data[a_idx];
          else            bus.ram_rdata = ram_phys[bus.cache_addr];
        end else begin
          cnt++;
        end
      end
    end
  end

  // ---------------- reference model: coherent cache view ----------------
  logic [DW-1:0] m_ram[256];
  logic [DW-1:0] m_data[16];
  logic [3:0]    m_t[16];
  bit            m_v[16];
  bit            m_d[16];
  int            m_lat;
  bit            m_err;
  int            m_hits, m_misses;
  int            force_q[$];
  logic [DW-1:0] exp_q[$];

  task automatic draw(output int d);
    if (force_q.size() > 0) d = force_q.pop_front();
    else                    d = int'($urandom_range(0, 2));
  endtask

  // One cache access at address a; latency accumulates in m_lat, timeout sets m_err.
  task automatic m_access(input logic [7:0] a, input bit rd, input logic [7:0] wd, output logic [7:0] dout);
    int idx, d;
    idx  = int'(a[3:0]);
    dout = '0;
    m_lat += 2;
    if (m_v[idx] && m_t[idx] == a[7:4]) begin
      m_hits++;
    end else begin
      m_misses++;
      if (m_v[idx] && m_d[idx]) begin
        draw(d); dly_q.push_back(d); we_q.push_back(1'b1);
        if (d >= TMO) begin m_lat += TMO; m_err = 1'b1; return; end
        m_lat += d + 1;
        m_ram[{m_t[idx], a[3:0]}] = m_data[idx];
      end
      if (rd) begin
        draw(d); dly_q.push_back(d); we_q.push_back(1'b0);
        if (d >= TMO) begin m_lat += TMO; m_err = 1'b1; return; end
        m_lat += d + 3;
        m_t[idx] = a[7:4]; m_v[idx] = 1'b1; m_d[idx] = 1'b0; m_data[idx] = m_ram[a];
      end
    end
    if (rd) begin
      dout = m_data[idx];
    end else begin
      m_lat += 1;
      m_t[idx] = a[7:4]; m_v[idx] = 1'b1; m_d[idx] = 1'b1; m_data[idx] = wd;
    end
  endtask

  task automatic run_txn(input logic [1:0] op, input bit ind, input logic [7:0] addr, input logic [7:0] wd);
    logic [7:0] a, p, dexp;
    bit got;
    int lat_obs;
    m_lat = 0; m_err = 1'b0; dexp = '0; p = '0; a = addr;
    if (op == 2'b00) begin
      for (int i = 0; i < 16; i++) begin m_v[i] = 1'b0; m_d[i] = 1'b0; end
      m_lat = 1; m_hits = 0; m_misses = 0;
    end else if (op == 2'b01) begin
      m_lat = 1; m_err = 1'b1;
    end else begin
      if (ind) begin
        m_access(a, 1'b1, 8'h00, p);
        if (!m_err) begin m_lat += 1; a = p; end
      end
      if (!m_err) m_access(a, op == 2'b10, wd, dexp);
      m_lat += 1;
    end
    force_q.delete();
    if (op == 2'b10 && !m_err) exp_q.push_back(dexp);

    check_eq("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_ind = ind;
    bus.req_addr = addr; bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    got = 1'b0; lat_obs = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      if (bus.rsp_valid) begin got = 1'b1; lat_obs = k + 1; end
      else begin @(posedge clk); #1; end
    end
    check_eq("rsp_seen", got, 1);
    if (got) begin
      check_eq("latency", lat_obs, m_lat);
      check_eq("rsp_err", bus.rsp_err, m_err);
      if (op == 2'b10 && !m_err) check_eq("rsp_rdata", bus.rsp_rdata, exp_q.pop_front());
      @(posedge clk); #1;
      check_eq("rsp_pulse_then_ready", {bus.rsp_valid, bus.req_ready}, 2'b01);
    end
    check_eq("ram_xfers_left", dly_q.size(), 0);
    dly_q.delete(); we_q.delete(); exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int r;
    bit got;
    logic [1:0] op;
    logic [7:0] addr;
    int mism;
    rst_n = 1'b0; env_init = 1'b1;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_ind = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      ram_phys[i] = 8'($urandom);
      m_ram[i]    = ram_phys[i];
    end
    ram_phys[8'h34] = 8'h77; m_ram[8'h34] = 8'h77;
    ram_phys[8'h10] = 8'h40; m_ram[8'h10] = 8'h40;
    ram_phys[8'h40] = 8'hC3; m_ram[8'h40] = 8'hC3;
    for (int i = 0; i < 16; i++) begin m_v[i] = 1'b0; m_d[i] = 1'b0; m_t[i] = '0; m_data[i] = '0; end
    m_hits = 0; m_misses = 0;

    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1; env_init = 1'b0;
    check_eq("rst_req_ready", bus.req_ready, 1);
    check_eq("rst_rsp_valid", bus.rsp_valid, 0);
    check_eq("rst_ram_req", bus.ram_req, 0);
    check_eq("rst_cache_op", bus.cache_op, 2'b10);

    run_txn(2'b11, 1'b0, 8'h12, 8'h5A);          // write miss clean
    run_txn(2'b10, 1'b0, 8'h12, 8'h00);          // read hit, 3 cycles, 0x5A
    run_txn(2'b11, 1'b0, 8'h24, 8'hAB);          // line 4 dirty
    force_q.push_back(2); force_q.push_back(2);
    run_txn(2'b10, 1'b0, 8'h34, 8'h00);          // evict + fill, fetch 0x77
    check_eq("wb_data_0x24", ram_phys[8'h24], 8'hAB);
    run_txn(2'b10, 1'b1, 8'h10, 8'h00);          // indirect through 0x40
    run_txn(2'b11, 1'b0, 8'h12, 8'hE1);          // write hit
    force_q.push_back(NEVER);
    run_txn(2'b10, 1'b0, 8'h56, 8'h00);          // fill timeout
    run_txn(2'b01, 1'b0, 8'h00, 8'h00);          // reserved op
    run_txn(2'b00, 1'b0, 8'h00, 8'h00);          // clear

    // Reset while the controller is waiting in EVICT.
    run_txn(2'b11, 1'b0, 8'h05, 8'h11);
    dly_q.push_back(NEVER); we_q.push_back(1'b1);
    bus.req_valid = 1'b1; bus.req_op = 2'b10; bus.req_ind = 1'b0; bus.req_addr = 8'h15;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      if (bus.ram_req) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check_eq("evict_reached", got, 1);
    check_eq("evict_we", bus.ram_we, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("midrst_ram_req", bus.ram_req, 0);
    check_eq("midrst_ready_rsp", {bus.req_ready, bus.rsp_valid}, 2'b10);
    rst_n = 1'b1;
    dly_q.delete(); we_q.delete();
    m_hits = 0; m_misses = 0;

    run_txn(2'b10, 1'b0, 8'h05, 8'h00);          // hit on retained dirty line
    run_txn(2'b10, 1'b0, 8'h05, 8'h00);
    run_txn(2'b10, 1'b0, 8'h25, 8'h00);          // miss dirty
`ifdef CACHE_STATS_EN
    check_eq("hit_cnt_2", hit_cnt, 2);
    check_eq("miss_cnt_1", miss_cnt, 1);
    run_txn(2'b00, 1'b0, 8'h00, 8'h00);
    check_eq("hit_cnt_clr", hit_cnt, 0);
    check_eq("miss_cnt_clr", miss_cnt, 0);
`endif

    for (int n = 0; n < 150; n++) begin
      r = int'($urandom_range(0, 19));
      op = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r < 11) ? 2'b10 : 2'b11;
      addr = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      if ($urandom_range(0, 24) == 0) force_q.push_back(NEVER);
      run_txn(op, $urandom_range(0, 3) == 0, addr, 8'($urandom));
`ifdef CACHE_STATS_EN
      check_eq("hit_cnt", hit_cnt, m_hits);
      check_eq("miss_cnt", miss_cnt, m_misses);
`endif
    end

    mism = 0;
    for (int i = 0; i < 256; i++) if (ram_phys[i] !== m_ram[i]) mism++;
    check_eq("ram_image_mismatches", mism, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
